// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word loads and stores over a word-wide memory,
// with a fixed access latency, misalignment detection and a one-cycle response pulse.
module data_mem_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int WORDS = 1 << (ADDR_W - 2);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

   logic [1:0]        state;
   logic [2:0]        cnt;
   logic              c_we;
   logic [1:0]        c_size;
   logic              c_uns;
   logic [ADDR_W-1:0] c_addr;
   logic [31:0]       c_wdata;
   logic [31:0]       mem [WORDS];

   logic [ADDR_W-3:0] widx;
   logic              req_bad;
   logic              do_access;
   logic [31:0]       word;
   logic [31:0]       shifted;
   logic [31:0]       ld;
   logic [3:0]        be;
   logic [31:0]       wd;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_W];
   assign widx      = c_addr[ADDR_W-1:2];
   assign do_access = (state == WAIT) && (cnt == '0);
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign resp_valid = (state == RESP);

   always_comb begin
      req_bad = 1'b0;
      case (req_size)
         2'b01:   req_bad = req_addr[0];
         2'b10:   req_bad = (req_addr[1:0] != 2'b00);
         2'b11:   req_bad = 1'b1;
         default: req_bad = 1'b0;
      endcase
   end

   // Loads: shift the addressed lane down to bit 0, then extend.
   always_comb begin
      word    = mem[widx];
      shifted = word >> {c_addr[1:0], 3'b000};
      ld      = shifted;
      case (c_size)
         2'b00:   ld = {{24{~c_uns & shifted[7]}}, shifted[7:0]};
         2'b01:   ld = {{16{~c_uns & shifted[15]}}, shifted[15:0]};
         default: ld = word;
      endcase
   end

   always_comb begin
      wd = c_wdata << {c_addr[1:0], 3'b000};
      be = 4'b1111;
      case (c_size)
         2'b00:   be = 4'b0001 << c_addr[1:0];
         2'b01:   be = 4'b0011 << c_addr[1:0];
         default: be = 4'b1111;
      endcase
   end

   // Memory is deliberately left out of reset; only the commit is gated by it.
   always_ff @(posedge clk) begin
      if (!rst && do_access && c_we) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (be[k]) mem[widx][8*k +: 8] <= wd[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  c_we    <= req_we;
                  c_size  <= req_size;
                  c_uns   <= req_unsigned;
                  c_addr  <= req_addr[ADDR_W-1:0];
                  c_wdata <= req_wdata;
                  if (req_bad) begin
                     state      <= RESP;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  state      <= RESP;
                  resp_err   <= 1'b0;
                  resp_rdata <= c_we ? '0 : ld;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: byte-address bits decoded; memory holds 2^(ADDR_W-2) 32-bit words.
REQ-002 Parameter LATENCY, default 1, legal range 1..7: clock edges from request accept to the response-state entry.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  in  1  loads: 1 zero-extends, 0 sign-extends.
REQ-010 req_addr  in  32  byte address; bits [31:ADDR_W] ignored.
REQ-011 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  out  1  one-cycle response pulse.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  out  1  access was misaligned or illegal-size.
REQ-015 busy  out  1  high whenever state is not IDLE; core stall source.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Accept = req_valid & req_ready at a rising edge; request fields are captured into internal registers at that edge and are not sampled again.
REQ-018 Legal accept: IDLE -> WAIT, counter loaded with LATENCY-1.
REQ-019 In WAIT: counter != 0 decrements; counter == 0 moves to RESP at that edge and performs the access.
REQ-020 Word index = captured addr[ADDR_W-1:2]; memory is little-endian, byte lane k = addr[1:0].
REQ-021 Stores: byte writes lane addr[1:0] only; half writes lanes {addr[1],0} and {addr[1],1}; word writes all lanes; other lanes are unchanged.
REQ-022 Loads: the selected byte/half/word is right-aligned, then zero- or sign-extended to 32 bits per req_unsigned.
REQ-023 Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or req_size=11: IDLE -> RESP directly; resp_err=1, resp_rdata=0, no memory write.
REQ-024 RESP lasts exactly one cycle with resp_valid=1, then returns to IDLE; there is no response backpressure.
REQ-025 resp_rdata and resp_err hold their values until the next RESP and are don't-care when resp_valid=0.
REQ-026 Latency: for a legal request, resp_valid is high in the cycle following edge accept+LATENCY; back-to-back throughput is one request per LATENCY+2 cycles.
REQ-027 Read-after-write: a load accepted after a store's RESP cycle returns the stored data.
REQ-028 req_valid while busy=1 is ignored and not queued; the requester holds it until req_ready.

Reset
REQ-029 On rst=1 at an edge: state=IDLE, counter=0, resp_valid=0, resp_err=0, resp_rdata=0; consequently req_ready=1 and busy=0.
REQ-030 Reset has priority over every transition; a store not yet in RESP when reset is applied is not committed.
REQ-031 Memory contents are not cleared by reset.

Verification
REQ-032 LATENCY=1: sw 0x10 0xDEADBEEF, then lw 0x10 -> rdata 0xDEADBEEF; lb 0x11 -> 0xFFFFFFBE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
REQ-033 sb 0x12 wdata 0x12345655, then lw 0x10 -> 0xDE55BEEF; sh 0x10 wdata 0xAAAA1234, then lw 0x10 -> 0xDE551234.
REQ-034 lw 0x12 -> resp_err=1, rdata=0 one edge after accept; sw 0x11 -> resp_err=1 and lw 0x10 still returns its prior value; size=11 -> resp_err=1.
REQ-035 LATENCY=3: accept at edge N -> busy=1 and req_ready=0 through the RESP cycle, resp_valid high only in the cycle after edge N+3; a req_valid held during WAIT is accepted only at the first IDLE edge.
REQ-036 Reset in WAIT during a sw 0x20 0x11111111 (prior value 0x0) -> next cycle IDLE, no resp_valid pulse; lw 0x20 -> 0x00000000.
REQ-037 Address aliasing, ADDR_W=10: sw 0x404 0xCAFEF00D, then lw 0x004 -> 0xCAFEF00D.
